// File: rtl/conv_encoder_framer.sv
// Rate-1/2, K=3 convolutional encoder with fixed-length framing and registered valid/ready output.
// Define CONV_ENC_TAIL_EN to append two zero tail symbols per frame; otherwise the state is flushed on the last data bit.
module conv_encoder_framer #(
  parameter int unsigned FRAME_LEN = 8,
  parameter logic [2:0]  G1        = 3'b111,
  parameter logic [2:0]  G0        = 3'b101
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_bit,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [1:0] y,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       sof,
  output logic       eof
);

  localparam int unsigned     CW       = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0]   LAST_CNT = CW'(FRAME_LEN - 1);
  localparam logic [5:0]      GEN      = {G1, G0};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
`ifdef CONV_ENC_TAIL_EN
  localparam logic [1:0] S_TAIL = 2'd2;
`endif

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic          d1_q, d1_d, d2_q, d2_d;
  logic [1:0]    y_q, y_d;
  logic          valid_q, valid_d;
  logic          sof_q, sof_d;
  logic          eof_q, eof_d;
  logic          slot_free, accept, last_bit, enc_x;
  logic [2:0]    taps;
  logic [1:0]    sym;
`ifdef CONV_ENC_TAIL_EN
  logic          tail_q, tail_d;
  logic          tail_load;
`endif

  assign slot_free = !valid_q || out_ready;
`ifdef CONV_ENC_TAIL_EN
  assign in_ready  = !reset && slot_free && (state_q != S_TAIL);
  assign tail_load = (state_q == S_TAIL) && slot_free;
`else
  assign in_ready  = !reset && slot_free;
`endif
  assign accept    = in_valid && in_ready;
  assign last_bit  = (bit_cnt_q == LAST_CNT);

  // Tail symbols are encoded with x forced to zero.
  assign enc_x = accept & in_bit;
  assign taps  = {enc_x, d1_q, d2_q};

  for (genvar gi = 0; gi < 2; gi++) begin : g_sym
    assign sym[gi] = ^(GEN[gi*3 +: 3] & taps);
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    d1_d      = d1_q;
    d2_d      = d2_q;
    y_d       = y_q;
    valid_d   = valid_q;
    sof_d     = sof_q;
    eof_d     = eof_q;
`ifdef CONV_ENC_TAIL_EN
    tail_d    = tail_q;
`endif
    if (accept) begin
      y_d     = sym;
      valid_d = 1'b1;
      sof_d   = (state_q == S_IDLE);
      eof_d   = 1'b0;
      d1_d    = in_bit;
      d2_d    = d1_q;
      if (last_bit) begin
        bit_cnt_d = '0;
`ifdef CONV_ENC_TAIL_EN
        state_d   = S_TAIL;
        tail_d    = 1'b0;
`else
        state_d   = S_IDLE;
        eof_d     = 1'b1;
        d1_d      = 1'b0;
        d2_d      = 1'b0;
`endif
      end else begin
        state_d   = S_DATA;
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
`ifdef CONV_ENC_TAIL_EN
    else if (tail_load) begin
      y_d     = sym;
      valid_d = 1'b1;
      sof_d   = 1'b0;
      eof_d   = tail_q;
      d1_d    = 1'b0;
      d2_d    = d1_q;
      tail_d  = !tail_q;
      if (tail_q) begin
        state_d = S_IDLE;
      end
    end
`endif
    else if (out_ready) begin
      valid_d = 1'b0;
      sof_d   = 1'b0;
      eof_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      d1_q      <= 1'b0;
      d2_q      <= 1'b0;
      y_q       <= 2'b00;
      valid_q   <= 1'b0;
      sof_q     <= 1'b0;
      eof_q     <= 1'b0;
`ifdef CONV_ENC_TAIL_EN
      tail_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      d1_q      <= d1_d;
      d2_q      <= d2_d;
      y_q       <= y_d;
      valid_q   <= valid_d;
      sof_q     <= sof_d;
      eof_q     <= eof_d;
`ifdef CONV_ENC_TAIL_EN
      tail_q    <= tail_d;
`endif
    end
  end

  assign y         = y_q;
  assign out_valid = valid_q;
  assign sof       = sof_q;
  assign eof       = eof_q;

endmodule

// File: tb/tb_conv_encoder_framer.sv
// Self-checking bench for conv_encoder_framer: directed frames, backpressure, reset, FRAME_LEN=1 streaming, random traffic.
module tb_conv_encoder_framer;

`ifdef CONV_ENC_TAIL_EN
  localparam int TAIL = 2;
`else
  localparam int TAIL = 0;
`endif
  localparam logic [2:0] G1_T = 3'b111;
  localparam logic [2:0] G0_T = 3'b101;
  localparam int FLEN_A = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic a_in_bit = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
  logic a_in_ready, a_out_valid, a_sof, a_eof;
  logic [1:0] a_y;
  logic b_in_bit = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic b_in_ready, b_out_valid, b_sof, b_eof;
  logic [1:0] b_y;

  int errors = 0;
  int checks = 0;

  logic [3:0] exp_q[$];   // {y, sof, eof} in output order
  bit         hist_q[$];  // data bits accepted so far in the current frame

  logic       tbits[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic [1:0] tsyms[6] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};

  always #5 clk = ~clk;

  conv_encoder_framer #(.FRAME_LEN(FLEN_A), .G1(G1_T), .G0(G0_T)) dut_a (
    .clk(clk), .reset(reset), .in_bit(a_in_bit), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .y(a_y), .out_valid(a_out_valid), .out_ready(a_out_ready), .sof(a_sof), .eof(a_eof)
  );

  conv_encoder_framer #(.FRAME_LEN(1), .G1(G1_T), .G0(G0_T)) dut_b (
    .clk(clk), .reset(reset), .in_bit(b_in_bit), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .y(b_y), .out_valid(b_out_valid), .out_ready(b_out_ready), .sof(b_sof), .eof(b_eof)
  );

  function automatic logic [1:0] code_sym(input bit x, input bit p1, input bit p2);
    logic [2:0] w;
    w = {x, p1, p2};
    return {1'($countones(G1_T & w) % 2), 1'($countones(G0_T & w) % 2)};
  endfunction

  // Append the symbols produced by accepting bit x, including the tail when the frame completes.
  function automatic void model_accept(input bit x);
    bit p1, p2, last;
    int n;
    n  = hist_q.size();
    p1 = (n >= 1) ? hist_q[n-1] : 1'b0;
    p2 = (n >= 2) ? hist_q[n-2] : 1'b0;
    hist_q.push_back(x);
    last = (hist_q.size() == FLEN_A);
    exp_q.push_back({code_sym(x, p1, p2), n == 0, last && (TAIL == 0)});
    if (last) begin
      if (TAIL == 2) begin
        exp_q.push_back({code_sym(1'b0, x, p1), 1'b0, 1'b0});
        exp_q.push_back({code_sym(1'b0, 1'b0, x), 1'b0, 1'b1});
      end
      hist_q.delete();
    end
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    a_in_valid = 1'b1; a_in_bit = 1'b1; a_out_ready = 1'b1;
    b_in_valid = 1'b1; b_in_bit = 1'b1; b_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_out_valid, a_y, a_sof, a_eof} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 00000", {a_out_valid, a_y, a_sof, a_eof});
    end
    checks++;
    if (a_in_ready !== 1'b0 || b_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready: got a=%b b=%b want 0", a_in_ready, b_in_ready);
    end
    reset = 1'b0;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    #1;
    checks++;
    if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_in_ready: got a=%b b=%b want 1", a_in_ready, b_in_ready);
    end
    $display("reset: done");
  endtask

  // Bits 1,0,1,1 at full throughput, checked symbol by symbol against the reference sequence.
  task automatic run_ref_frame(input string tag);
    int acc = 0;
    int nsym = FLEN_A + TAIL;
    logic exp_rdy;
    for (int cyc = 0; cyc <= nsym; cyc++) begin
      @(negedge clk);
      a_in_valid  = (acc < 4);
      a_in_bit    = (acc < 4) ? tbits[acc] : 1'b0;
      a_out_ready = 1'b1;
      #1;
      exp_rdy = !(TAIL == 2 && (cyc == 4 || cyc == 5));
      checks++;
      if (a_in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL %s_in_ready cyc%0d: got %b want %b", tag, cyc, a_in_ready, exp_rdy);
      end
      checks++;
      if (cyc == 0) begin
        if (a_out_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s_idle_valid: got %b want 0", tag, a_out_valid);
        end
      end else if ({a_out_valid, a_y, a_sof, a_eof} !== {1'b1, tsyms[cyc-1], cyc == 1, cyc == nsym}) begin
        errors++;
        $display("FAIL %s_sym%0d: got v=%b y=%b sof=%b eof=%b want v=1 y=%b sof=%b eof=%b", tag, cyc - 1,
                 a_out_valid, a_y, a_sof, a_eof, tsyms[cyc-1], cyc == 1, cyc == nsym);
      end
      if (a_in_valid && a_in_ready) acc++;
    end
    $display("%s: frame of %0d symbols", tag, nsym);
  endtask

  task automatic test_frame();
    run_ref_frame("frame");
    @(negedge clk);
    a_in_valid = 1'b1; a_in_bit = 1'b1; a_out_ready = 1'b1;
    #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL frame_gap: got v=%b rdy=%b want v=0 rdy=1", a_out_valid, a_in_ready);
    end
    @(negedge clk);
    a_in_valid = 1'b0;
    #1;
    checks++;
    if ({a_out_valid, a_y, a_sof, a_eof} !== 5'b11110) begin
      errors++;
      $display("FAIL next_frame_first: got %b want 11110", {a_out_valid, a_y, a_sof, a_eof});
    end
    $display("frame: next frame bit 1 -> y=%b sof=%b", a_y, a_sof);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    a_in_valid = 1'b1; a_in_bit = 1'b0; a_out_ready = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({a_out_valid, a_y, a_sof, a_eof} !== 5'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %b want 00000", {a_out_valid, a_y, a_sof, a_eof});
    end
    run_ref_frame("reset_mid");
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int popped = 0;
    logic exp_rdy;
    exp_q.delete();
    hist_q.delete();
    for (int cyc = 0; cyc < 40 && (cyc == 0 || exp_q.size() > 0 || acc < 4); cyc++) begin
      @(negedge clk);
      a_in_valid  = (acc < 4);
      a_in_bit    = (acc < 4) ? tbits[acc] : 1'b0;
      a_out_ready = !(cyc >= 1 && cyc <= 3);
      #1;
      exp_rdy = (exp_q.size() == 0 || a_out_ready) && exp_q.size() <= 1;
      checks++;
      if (a_in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL bp_in_ready cyc%0d: got %b want %b", cyc, a_in_ready, exp_rdy);
      end
      if (cyc >= 1 && cyc <= 3) begin
        checks++;
        if (a_out_valid !== 1'b1 || a_y !== 2'b11) begin
          errors++;
          $display("FAIL bp_hold cyc%0d: got v=%b y=%b want v=1 y=11", cyc, a_out_valid, a_y);
        end
      end
      checks++;
      if (exp_q.size() == 0) begin
        if (a_out_valid !== 1'b0) begin
          errors++;
          $display("FAIL bp_valid cyc%0d: got %b want 0", cyc, a_out_valid);
        end
      end else if (a_out_valid !== 1'b1 || {a_y, a_sof, a_eof} !== exp_q[0]) begin
        errors++;
        $display("FAIL bp_sym cyc%0d: got v=%b %b want v=1 %b", cyc, a_out_valid, {a_y, a_sof, a_eof}, exp_q[0]);
      end
      if (exp_q.size() > 0 && a_out_ready) begin
        void'(exp_q.pop_front());
        popped++;
      end
      if (a_in_valid && exp_rdy) begin
        model_accept(a_in_bit);
        acc++;
      end
    end
    checks++;
    if (popped !== FLEN_A + TAIL || acc !== 4) begin
      errors++;
      $display("FAIL bp_count: got popped=%0d acc=%0d want %0d and 4", popped, acc, FLEN_A + TAIL);
    end
    $display("backpressure: %0d symbols delivered", popped);
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    int nsym = 2 * (1 + TAIL);
    int pos;
    logic [1:0] want;
    for (int cyc = 0; cyc <= nsym; cyc++) begin
      @(negedge clk);
      b_in_valid  = (acc < 2);
      b_in_bit    = 1'b1;
      b_out_ready = 1'b1;
      #1;
      checks++;
      if (cyc == 0) begin
        if (b_out_valid !== 1'b0) begin
          errors++;
          $display("FAIL b2b_idle_valid: got %b want 0", b_out_valid);
        end
      end else begin
        pos  = (cyc - 1) % (1 + TAIL);
        want = (pos == 1) ? 2'b10 : 2'b11;
        if ({b_out_valid, b_y, b_sof, b_eof} !== {1'b1, want, pos == 0, pos == TAIL}) begin
          errors++;
          $display("FAIL b2b_sym%0d: got v=%b y=%b sof=%b eof=%b want v=1 y=%b sof=%b eof=%b", cyc - 1,
                   b_out_valid, b_y, b_sof, b_eof, want, pos == 0, pos == TAIL);
        end
      end
      if (b_in_valid && b_in_ready) acc++;
    end
    b_in_valid = 1'b0;
    checks++;
    if (acc !== 2) begin
      errors++;
      $display("FAIL b2b_accepted: got %0d want 2", acc);
    end
    $display("back_to_back: %0d symbols", nsym);
  endtask

  task automatic test_random();
    int popped = 0;
    logic exp_rdy;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      if (cyc < 780) begin
        a_in_valid  = ($urandom_range(0, 3) != 0);
        a_in_bit    = $urandom_range(0, 1);
        a_out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
      end
      #1;
      exp_rdy = (exp_q.size() == 0 || a_out_ready) && exp_q.size() <= 1;
      checks++;
      if (a_in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL rnd_in_ready cyc%0d: got %b want %b", cyc, a_in_ready, exp_rdy);
      end
      checks++;
      if (exp_q.size() == 0) begin
        if (a_out_valid !== 1'b0) begin
          errors++;
          $display("FAIL rnd_valid cyc%0d: got %b want 0", cyc, a_out_valid);
        end
      end else if (a_out_valid !== 1'b1 || {a_y, a_sof, a_eof} !== exp_q[0]) begin
        errors++;
        $display("FAIL rnd_sym cyc%0d: got v=%b %b want v=1 %b", cyc, a_out_valid, {a_y, a_sof, a_eof}, exp_q[0]);
      end
      if (exp_q.size() > 0 && a_out_ready) begin
        void'(exp_q.pop_front());
        popped++;
      end
      if (a_in_valid && exp_rdy) model_accept(a_in_bit);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL rnd_drain: got %0d pending want 0", exp_q.size());
    end
    $display("random: %0d symbols checked", popped);
  endtask

  initial begin
    test_reset();
    test_frame();
    test_reset_mid();
    test_backpressure();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_encoder_framer.md
# conv_encoder_framer

Rate-1/2, constraint-length-3 convolutional encoder that converts a serial data-bit stream into the 2-bit code symbols consumed by the downstream 4-state decoder. It accepts bits over a valid/ready handshake, encodes them into fixed-length frames, and appends two zero tail bits so every frame ends in state 00. The decoder's reset state is 00, so no extra alignment is needed. Output symbols are registered and presented over a valid/ready handshake with start- and end-of-frame markers.

## Interface
- FRAME_LEN, 8: data bits per frame; legal range 1..65535.
- G1, 3'b111: generator for y[1]; bit 2 taps the current input, bit 1 taps d1, bit 0 taps d2.
- G0, 3'b101: generator for y[0]; same bit mapping as G1.
- clk  input  1  single clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_bit  input  1  data bit x.
- in_valid  input  1  in_bit is valid.
- in_ready  output  1  encoder accepts in_bit this cycle.
- y  output  2  code symbol {y[1], y[0]}.
- out_valid  output  1  y, sof and eof are valid.
- out_ready  input  1  downstream accepts the symbol this cycle.
- sof  output  1  this is the first symbol of the frame.
- eof  output  1  this is the last symbol of the frame.

## Operation
- Shift register {d1,d2}: d1 is the previous bit, d2 the bit before it. After each encoded bit x: d1<=x, d2<=d1.
- Symbol bits: y[k] = XOR-reduce(Gk & {x,d1,d2}). With the default generators, y[1]=x^d1^d2 and y[0]=x^d2.
- FSM states:
  - IDLE: {d1,d2}=00. A bit accepted here is data bit 0 and goes to DATA.
  - DATA: bit_cnt counts accepted bits. On acceptance of bit FRAME_LEN-1, go to TAIL.
  - TAIL: generates two internal x=0 symbols, one per output slot. in_ready=0 throughout. After the second tail symbol is loaded, go to IDLE with {d1,d2}=00.
- Accept/load rule: out_slot_free = !out_valid || out_ready.
  - in_ready = out_slot_free && state != TAIL.
  - A bit is accepted when in_valid && in_ready. The resulting symbol loads into the output register that same edge.
- sof=1 on the symbol of data bit 0.
- eof=1 on the second tail symbol.
- FRAME_LEN=1 is legal: that symbol carries sof, and the frame is 3 symbols long.
- Symbols per frame: FRAME_LEN+2.
- Backpressure: while out_valid && !out_ready, y, sof, eof and out_valid hold, and no bit is accepted.
- Counter width: $clog2(FRAME_LEN+1); the counter resets to 0 at the start of each frame.

## Timing
- Reset values: y=00, out_valid=0, sof=0, eof=0, in_ready=0 during the reset cycle, state IDLE, {d1,d2}=00, bit_cnt=0.
- in_ready=1 on the first cycle after reset is released.
- Latency: the symbol appears on the edge that accepts the bit; out_valid is high in the next cycle.
- Full throughput: 1 symbol per cycle when out_ready is held at 1. A frame takes FRAME_LEN+2 cycles, and the next frame's bit 0 can be accepted in the cycle after the last tail symbol loads.
- Simultaneous out_ready and acceptance: the old symbol drains and the new one loads on the same edge, with no bubble.
- Reset mid-frame: the frame is abandoned immediately. No eof is emitted and the pending symbol is discarded (out_valid=0). The next accepted bit starts a new frame with sof.
- in_valid dropping mid-frame: the FSM stays in DATA and bit_cnt holds. There is no timeout.

## Configuration
- CONV_ENC_TAIL_EN defined:
  - Tail insertion as described; frame length is FRAME_LEN+2 symbols.
  - eof is on the second tail symbol.
- CONV_ENC_TAIL_EN undefined:
  - The TAIL state is removed and no tail symbols are sent; frame length is FRAME_LEN symbols.
  - eof is on the symbol of data bit FRAME_LEN-1.
  - {d1,d2} is cleared to 00 on that same edge, so the next frame still starts from state 00.

## Test plan
- Default generators, FRAME_LEN=4, bits 1,0,1,1, out_ready=1 -> symbols 11,10,00,01,01,11 on consecutive cycles; sof on the first symbol, eof on the sixth; in_ready=0 for the two tail cycles.
- Same stimulus with CONV_ENC_TAIL_EN undefined -> symbols 11,10,00,01 with eof on 01; the next frame's bit 1 yields 11.
- Backpressure: out_ready=0 for 3 cycles after the first symbol -> y=11 holds and in_ready=0; after release, the sequence resumes unchanged with no lost or duplicated symbol.
- Reset asserted after 2 bits of a frame -> next cycle out_valid=0, y=00, sof=0, eof=0; then bits 1,0,1,1 reproduce the sequence from the first scenario exactly.
- Back-to-back frames, FRAME_LEN=1, bits 1,1, out_ready=1 -> 11,10,11 then 11,10,11 with no idle cycle; sof and eof on symbols 1/3 and 4/6 respectively.
